// File: rtl/encoder_16x4.sv
// Sequential 16-to-4 priority encoder. It collects request lines into a pending set and
// hands out one index per ready/valid transfer. Define ENCODER_RR_EN to get round-robin selection.
module encoder_16x4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] inputs,
    input  logic        ready,
    output logic [3:0]  outputs,
    output logic        valid,
    output logic [4:0]  count,
    output logic        overflow
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]  state_q,    state_d;
    logic [15:0] pending_q,  pending_d;
    logic [3:0]  outputs_q,  outputs_d;
    logic [4:0]  count_q,    count_d;
    logic        overflow_q, overflow_d;

    logic        accept;
    logic [15:0] pop_mask;
    logic [15:0] cand;
    logic [3:0]  next_sel;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

`ifdef ENCODER_RR_EN
    logic [3:0] rr_ptr_q, rr_ptr_d;

    // The search starts just past the last granted index. The 4-bit add wraps 15 back to 0.
    function automatic logic [3:0] sel_rr(input logic [15:0] v, input logic [3:0] last);
        logic [3:0] start;
        logic [3:0] pos;
        logic [3:0] idx;
        start = last + 4'd1;
        idx   = '0;
        for (int i = 15; i >= 0; i--) begin
            pos = start + 4'(i);
            if (v[pos]) idx = pos;
        end
        return idx;
    endfunction
`else
    function automatic logic [3:0] sel_lowest(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction
`endif

    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        accept     = (state_q == ST_HOLD) && ready;
        pop_mask   = accept ? (16'd1 << outputs_q) : 16'd0;
        pending_d  = (pending_q & ~pop_mask) | inputs;
        overflow_d = overflow_q | (|(inputs & pending_q & ~pop_mask));
        count_d    = popcount16(pending_d);

        // In HOLD the next index comes from the post-transfer set. In IDLE it comes from the current set.
        cand = (state_q == ST_HOLD) ? pending_d : pending_q;
`ifdef ENCODER_RR_EN
        rr_ptr_d = accept ? outputs_q : rr_ptr_q;
        next_sel = sel_rr(cand, rr_ptr_d);
`else
        next_sel = sel_lowest(cand);
`endif

        state_d   = state_q;
        outputs_d = outputs_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    outputs_d = next_sel;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    if (|pending_d) begin
                        outputs_d = next_sel;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            outputs_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            outputs_q  <= outputs_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef ENCODER_RR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= 4'd15;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign outputs  = outputs_q;
    assign valid    = (state_q == ST_HOLD);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_encoder_16x4.sv
// Directed bench for encoder_16x4. A vector table covers reset, single-request and drain cases.
// Hand sequences cover backpressure, overflow, full set, mid-transfer reset and selection order.
module tb_encoder_16x4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] inputs;
    logic        ready;
    logic [3:0]  outputs;
    logic        valid;
    logic [4:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    encoder_16x4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inputs   (inputs),
        .ready    (ready),
        .outputs  (outputs),
        .valid    (valid),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [15:0] in;
        logic        rdy;
        logic        exp_valid;
        logic [3:0]  exp_out;
        logic [4:0]  exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic add(input string name, input logic r, input logic [15:0] in, input logic rdy,
                       input logic ev, input logic [3:0] eo, input logic [4:0] ec, input logic eov);
        vec_t v;
        v.name = name; v.rst_n = r; v.in = in; v.rdy = rdy;
        v.exp_valid = ev; v.exp_out = eo; v.exp_cnt = ec; v.exp_ovf = eov;
        vecs.push_back(v);
    endtask

    // Drive inputs for one edge, then sample the outputs 1 ns after that edge.
    task automatic step(input string name, input logic r, input logic [15:0] in, input logic rdy,
                        input logic ev, input logic [3:0] eo, input logic [4:0] ec, input logic eov);
        rst_n  = r;
        inputs = in;
        ready  = rdy;
        @(posedge clk);
        #1;
        check({name, ".valid"}, 32'(valid), 32'(ev));
        check({name, ".count"}, 32'(count), 32'(ec));
        check({name, ".overflow"}, 32'(overflow), 32'(eov));
        if (ev || !r) check({name, ".outputs"}, 32'(outputs), 32'(eo));
    endtask

    initial begin
        rst_n  = 1'b0;
        inputs = '0;
        ready  = 1'b0;

        // name, rst_n, inputs, ready, exp valid, exp outputs, exp count, exp overflow
        add("rst0",   1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0,  5'd0, 1'b0);
        add("rst1",   1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0,  5'd0, 1'b0);
        add("rst2",   1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0,  5'd0, 1'b0);
        add("single0",1'b1, 16'h0100, 1'b1, 1'b0, 4'd0,  5'd1, 1'b0);
        add("single1",1'b1, 16'h0000, 1'b1, 1'b1, 4'd8,  5'd1, 1'b0);
        add("single2",1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  5'd0, 1'b0);
        add("drain0", 1'b1, 16'h8421, 1'b1, 1'b0, 4'd0,  5'd4, 1'b0);
        add("drain1", 1'b1, 16'h0000, 1'b1, 1'b1, 4'd0,  5'd4, 1'b0);
        add("drain2", 1'b1, 16'h0000, 1'b1, 1'b1, 4'd5,  5'd3, 1'b0);
        add("drain3", 1'b1, 16'h0000, 1'b1, 1'b1, 4'd10, 5'd2, 1'b0);
        add("drain4", 1'b1, 16'h0000, 1'b1, 1'b1, 4'd15, 5'd1, 1'b0);
        add("drain5", 1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  5'd0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].rst_n, vecs[i].in, vecs[i].rdy,
                 vecs[i].exp_valid, vecs[i].exp_out, vecs[i].exp_cnt, vecs[i].exp_ovf);
        end

        // Backpressure: index 4 stays frozen while a lower request arrives behind it.
        step("bp_load", 1'b1, 16'h0010, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0);
        step("bp_hold0",1'b1, 16'h0000, 1'b0, 1'b1, 4'd4, 5'd1, 1'b0);
        step("bp_hold1",1'b1, 16'h0000, 1'b0, 1'b1, 4'd4, 5'd1, 1'b0);
        step("bp_pulse",1'b1, 16'h0001, 1'b0, 1'b1, 4'd4, 5'd2, 1'b0);
        step("bp_hold3",1'b1, 16'h0000, 1'b0, 1'b1, 4'd4, 5'd2, 1'b0);
        step("bp_hold4",1'b1, 16'h0000, 1'b0, 1'b1, 4'd4, 5'd2, 1'b0);
        step("bp_pop4", 1'b1, 16'h0000, 1'b1, 1'b1, 4'd0, 5'd1, 1'b0);
        step("bp_pop0", 1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0);

        // Set wins: bit 4 is requested in the same cycle it is popped, so it is presented again.
        step("sw_load", 1'b1, 16'h0010, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0);
        step("sw_pres", 1'b1, 16'h0000, 1'b0, 1'b1, 4'd4, 5'd1, 1'b0);
        step("sw_same", 1'b1, 16'h0010, 1'b1, 1'b1, 4'd4, 5'd1, 1'b0);
        step("sw_done", 1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0);

        // Overflow: a duplicate request for a pending bit is merged, and the flag stays set until reset.
        step("ov_load", 1'b1, 16'h0010, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0);
        step("ov_dup",  1'b1, 16'h0010, 1'b0, 1'b1, 4'd4, 5'd1, 1'b1);
        step("ov_pop",  1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 5'd0, 1'b1);
        step("ov_stick",1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 5'd0, 1'b1);
        step("ov_rst",  1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);

        // Full set, partial drain, then a reset mid-transfer drops everything.
        step("full_load",1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0, 5'd16, 1'b0);
        step("full_pres",1'b1, 16'h0000, 1'b1, 1'b1, 4'd0, 5'd16, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step($sformatf("full_pop%0d", i), 1'b1, 16'h0000, 1'b1, 1'b1, 4'(i), 5'(16 - i), 1'b0);
        end
        step("mid_rst",  1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0);
        step("mid_after",1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0);

        // Two requests held high with ready=1. The second cycle already flags overflow.
        step("sel_load", 1'b1, 16'h0003, 1'b1, 1'b0, 4'd0, 5'd2, 1'b0);
        step("sel_0",    1'b1, 16'h0003, 1'b1, 1'b1, 4'd0, 5'd2, 1'b1);
`ifdef ENCODER_RR_EN
        step("sel_1",    1'b1, 16'h0003, 1'b1, 1'b1, 4'd1, 5'd2, 1'b1);
        step("sel_2",    1'b1, 16'h0003, 1'b1, 1'b1, 4'd0, 5'd2, 1'b1);
`else
        step("sel_1",    1'b1, 16'h0003, 1'b1, 1'b1, 4'd0, 5'd2, 1'b1);
        step("sel_2",    1'b1, 16'h0003, 1'b1, 1'b1, 4'd0, 5'd2, 1'b1);
`endif
        step("sel_3",    1'b1, 16'h0000, 1'b1, 1'b1, 4'd1, 5'd1, 1'b1);
        step("sel_end",  1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 5'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
